exit_sequencer: RTL and testbench

Arbitrates end-of-simulation exit requests from several harts or testbench agents. It collects their exit codes and waits for outstanding console output to drain. It then emits a single one-cycle {finish, exitcode} word on the 9-bit argument input of the simulation-finish external module. It sits between the cores' tohost/exit logic and the finish module, so that several exit sources share the one finish path.

---
 rtl/exit_sequencer.sv | 124 ++++++++++++
 tb/tb_exit_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exit_sequencer.sv
// Collects exit requests from several sources, waits for console drain,
// then issues a single one-cycle {finish, exitcode} word to the finish module.
`timescale 1ns/1ps
module exit_sequencer #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned DRAIN    = 16,
    parameter int unsigned ALL_MODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_code,
    output logic [NREQ-1:0]   req_ready,
    input  logic              tx_busy,
    output logic [8:0]        finish_out,
    output logic              halted
);
    localparam int unsigned PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DRAIN,
        ST_FIRE,
        ST_HALT
    } state_t;

    state_t          r_state, w_state_n;
    logic [NREQ-1:0] r_done, w_done_n;
    logic [7:0]      r_code, w_code_n;
    logic [PW-1:0]   r_rr, w_rr_n;
    logic [7:0]      r_cnt, w_cnt_n;
    logic [8:0]      r_finish, w_finish_n;

    logic            w_found;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_idx;
    logic [NREQ-1:0] w_grant;
    logic [7:0]      w_gcode;

    // Round-robin search starting at r_rr; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = PW'((32'(r_rr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_gcode = req_code[8*w_gidx +: 8];

    always_comb begin
        w_state_n = r_state;
        w_done_n  = r_done;
        w_code_n  = r_code;
        w_rr_n    = r_rr;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_COLLECT: begin
                if (w_found) begin
                    w_done_n[w_gidx] = 1'b1;
                    if (r_code == 8'h00) begin
                        w_code_n = w_gcode;
                    end
                    w_rr_n = PW'((32'(w_gidx) + 1) % NREQ);
                    if (ALL_MODE == 0 || (&w_done_n)) begin
                        if (DRAIN == 0) begin
                            w_state_n = ST_FIRE;
                        end else begin
                            w_state_n = ST_DRAIN;
                            w_cnt_n   = DRAIN_LOAD;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (tx_busy) begin
                    w_cnt_n = DRAIN_LOAD;
                end else if (r_cnt > 8'd1) begin
                    w_cnt_n = r_cnt - 8'd1;
                end else begin
                    w_state_n = ST_FIRE;
                end
            end
            ST_FIRE: w_state_n = ST_HALT;
            ST_HALT: w_state_n = ST_HALT;
        endcase
        // Finish word is registered so it appears exactly during the FIRE cycle.
        w_finish_n = (w_state_n == ST_FIRE) ? {1'b1, w_code_n} : 9'h000;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_COLLECT;
            r_done   <= '0;
            r_code   <= '0;
            r_rr     <= '0;
            r_cnt    <= '0;
            r_finish <= '0;
        end else begin
            r_state  <= w_state_n;
            r_done   <= w_done_n;
            r_code   <= w_code_n;
            r_rr     <= w_rr_n;
            r_cnt    <= w_cnt_n;
            r_finish <= w_finish_n;
        end
    end

    // Outside COLLECT every request is sunk so late requesters never stall.
    assign req_ready  = (r_state == ST_COLLECT) ? w_grant : '1;
    assign finish_out = r_finish;
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_exit_sequencer.sv
// Scoreboard bench for exit_sequencer: two instances (first-request/drain 4 and
// all-requesters/no-drain) checked against a behavioural model.
`timescale 1ns/1ps
module tb_exit_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_code  = '0;
    logic        tx_busy   = 1'b0;

    logic [1:0][1:0] d_rdy;
    logic [1:0][8:0] d_fin;
    logic [1:0]      d_hlt;

    always #5 CLK = ~CLK;

    exit_sequencer #(.NREQ(2), .DRAIN(4), .ALL_MODE(0)) u_any (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_code(req_code),
        .req_ready(d_rdy[0]), .tx_busy(tx_busy), .finish_out(d_fin[0]), .halted(d_hlt[0])
    );

    exit_sequencer #(.NREQ(2), .DRAIN(0), .ALL_MODE(1)) u_all (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_code(req_code),
        .req_ready(d_rdy[1]), .tx_busy(tx_busy), .finish_out(d_fin[1]), .halted(d_hlt[1])
    );

    typedef struct packed {
        logic [1:0][1:0] rdy;
        logic [1:0][8:0] fin;
        logic [1:0]      hlt;
        int unsigned     cyc;
    } exp_t;

    exp_t       expq[$];
    logic [8:0] evq0[$];
    logic [8:0] evq1[$];

    // Model: phase 0 collecting, 1 waiting for idle console, 2 firing, 3 halted.
    int          m_phase[2];
    int          m_idle[2];
    int          m_ptr[2];
    logic [1:0]  m_done[2];
    logic [7:0]  m_code[2];
    bit          m_known = 1'b0;
    int unsigned tcyc    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int drain_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic bit all_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [1:0] model_ready(input int k);
        int idx;
        if (m_phase[k] != 0) return 2'b11;
        for (int j = 0; j < 2; j++) begin
            idx = (m_ptr[k] + j) % 2;
            if (req_valid[idx]) return (idx == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic model_step(input int k);
        logic [1:0] g;
        int gi;
        if (RST) begin
            m_phase[k] = 0; m_idle[k] = 0; m_ptr[k] = 0;
            m_done[k] = 2'b00; m_code[k] = 8'h00;
            return;
        end
        case (m_phase[k])
            0: begin
                g = model_ready(k);
                if (g != 2'b00) begin
                    gi = g[1] ? 1 : 0;
                    m_done[k][gi] = 1'b1;
                    if (m_code[k] == 8'h00) m_code[k] = (gi == 1) ? req_code[15:8] : req_code[7:0];
                    m_ptr[k] = (gi + 1) % 2;
                    if (!all_of(k) || m_done[k] == 2'b11) begin
                        m_idle[k]  = 0;
                        m_phase[k] = (drain_of(k) == 0) ? 2 : 1;
                    end
                end
            end
            1: begin
                m_idle[k] = tx_busy ? 0 : m_idle[k] + 1;
                if (m_idle[k] == drain_of(k)) m_phase[k] = 2;
            end
            2: m_phase[k] = 3;
            default: ;
        endcase
        if (m_phase[k] == 2) begin
            if (k == 0) evq0.push_back({1'b1, m_code[k]});
            else        evq1.push_back({1'b1, m_code[k]});
        end
    endtask

    task automatic drive(input bit rst, input logic [1:0] v, input logic [15:0] code, input bit busy);
        exp_t e;
        @(posedge CLK); #1;
        RST = rst; req_valid = v; req_code = code; tx_busy = busy;
        tcyc++;
        if (m_known) begin
            for (int k = 0; k < 2; k++) begin
                e.rdy[k] = model_ready(k);
                e.fin[k] = (m_phase[k] == 2) ? {1'b1, m_code[k]} : 9'h000;
                e.hlt[k] = (m_phase[k] == 3);
            end
            e.cyc = tcyc;
            expq.push_back(e);
        end
        for (int k = 0; k < 2; k++) model_step(k);
        if (rst) m_known = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 16'h0000, 1'b0);
    endtask

    task automatic check(input string name, input int k, input logic [8:0] got,
                         input logic [8:0] want, input int unsigned c);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, k, c, got, want);
        end
    endtask

    // Monitor: per-cycle outputs plus finish-word events whenever a DUT fires.
    initial begin
        exp_t e;
        logic [8:0] w;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check("ready",  k, {7'd0, d_rdy[k]}, {7'd0, e.rdy[k]}, e.cyc);
                    check("finish", k, d_fin[k], e.fin[k], e.cyc);
                    check("halted", k, {8'd0, d_hlt[k]}, {8'd0, e.hlt[k]}, e.cyc);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (d_fin[k][8] === 1'b1) begin
                    if ((k == 0 ? evq0.size() : evq1.size()) == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL finish_evt[%0d] unexpected got=%h want=none", k, d_fin[k]);
                    end else begin
                        w = (k == 0) ? evq0.pop_front() : evq1.pop_front();
                        check("finish_evt", k, d_fin[k], w, tcyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  v;
        logic [15:0] c;
        // Reset, then requester 0 with code 0.
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b01, 16'h0000, 1'b0);
        idle(8);
        // Requester 1 code 0x05, requester 0 code 0x07 three cycles later.
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b10, 16'h0500, 1'b0);
        idle(2);
        drive(1'b0, 2'b01, 16'h0007, 1'b0);
        idle(8);
        // Simultaneous requests on two consecutive cycles.
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b11, 16'h3300, 1'b0);
        drive(1'b0, 2'b11, 16'h3344, 1'b0);
        idle(8);
        // Console busy for 10 cycles inside the drain window.
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b01, 16'h0011, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b00, 16'h0000, 1'b1);
        idle(8);
        // Reset mid-drain, then a complete new sequence.
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b10, 16'h2200, 1'b0);
        idle(2);
        drive(1'b1, 2'b00, 16'h0000, 1'b0);
        drive(1'b0, 2'b01, 16'h00a5, 1'b0);
        drive(1'b0, 2'b10, 16'h5a00, 1'b0);
        idle(8);
        // Late requests while halted.
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b11, 16'hffff, 1'b0);
        idle(3);
        // Randomised traffic.
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 2'b00, 16'h0000, 1'b0);
            for (int i = 0; i < 40; i++) begin
                v = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
                c[7:0]  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                c[15:8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                drive(($urandom_range(0, 49) == 0), v, c, ($urandom_range(0, 3) == 0));
            end
        end
        idle(4);
        @(negedge CLK); #1;
        check("expq_drained", 0, 9'(expq.size()), 9'd0, tcyc);
        check("evq_drained",  0, 9'(evq0.size()), 9'd0, tcyc);
        check("evq_drained",  1, 9'(evq1.size()), 9'd0, tcyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
